// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants, state encodings and helpers for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

  localparam int REGFILE_ADDRESS_LEN = 4;
  localparam int PERF_LEN_DEFAULT    = 16;
  localparam int MEM_TIMEOUT_DEFAULT = 255;
  localparam int WATCHDOG_LEN        = 16;

  // Controller FSM encodings (2-bit, kept as plain constants for legacy tools)
  localparam logic [1:0] PCTRL_RUN      = 2'd0;
  localparam logic [1:0] PCTRL_MEM_WAIT = 2'd1;
  localparam logic [1:0] PCTRL_ERROR    = 2'd2;

  typedef logic [REGFILE_ADDRESS_LEN-1:0] reg_addr_t;

  // One RAW term: a source that is read, matched against a destination that is written
  function automatic logic src_match(input logic used, input reg_addr_t src,
                                     input logic wb_en, input reg_addr_t dest);
    return used & wb_en & (src == dest);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/branch/SRAM inputs and stage-control outputs of the pipeline controller.
interface pipeline_ctrl_if #(
  parameter int PERF_LEN = 16
) ();
  import pipeline_ctrl_pkg::*;

  logic                forward_en;
  reg_addr_t           id_src1;
  reg_addr_t           id_src2;
  logic                id_use_src1;
  logic                id_two_src;
  reg_addr_t           exe_dest;
  logic                exe_wb_en;
  logic                exe_mem_read;
  reg_addr_t           mem_dest;
  logic                mem_wb_en;
  logic                exe_branch_taken;
  logic                mem_access_req;
  logic                mem_ready;
  logic                pipe_freeze;
  logic                if_freeze;
  logic                if_flush;
  logic                id_flush;
  logic                hazard;
  logic                mem_timeout_err;
  logic [PERF_LEN-1:0] stall_count;
  logic [PERF_LEN-1:0] flush_count;

  // The pipeline datapath side drives the status and reads the controls
  modport master (
    output forward_en, id_src1, id_src2, id_use_src1, id_two_src,
           exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
           exe_branch_taken, mem_access_req, mem_ready,
    input  pipe_freeze, if_freeze, if_flush, id_flush, hazard,
           mem_timeout_err, stall_count, flush_count
  );

  // The controller reads the status and drives the controls
  modport slave (
    input  forward_en, id_src1, id_src2, id_use_src1, id_two_src,
           exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
           exe_branch_taken, mem_access_req, mem_ready,
    output pipe_freeze, if_freeze, if_flush, id_flush, hazard,
           mem_timeout_err, stall_count, flush_count
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational RAW hazard detector; the forwarding mode decides which producers matter.
module pipeline_ctrl_hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic      forward_en,
  input  reg_addr_t id_src1,
  input  reg_addr_t id_src2,
  input  logic      id_use_src1,
  input  logic      id_two_src,
  input  reg_addr_t exe_dest,
  input  logic      exe_wb_en,
  input  logic      exe_mem_read,
  input  reg_addr_t mem_dest,
  input  logic      mem_wb_en,
  output logic      hazard
);

  logic exe_hit_s;
  logic mem_hit_s;

  // With forwarding only a load in EX cannot be bypassed; without it every pending write stalls
  always_comb begin
    exe_hit_s = src_match(id_use_src1, id_src1, exe_wb_en, exe_dest) |
                src_match(id_two_src,  id_src2, exe_wb_en, exe_dest);
    mem_hit_s = src_match(id_use_src1, id_src1, mem_wb_en, mem_dest) |
                src_match(id_two_src,  id_src2, mem_wb_en, mem_dest);
    if (forward_en) begin
      hazard = exe_mem_read & exe_hit_s;
    end else begin
      hazard = exe_hit_s | mem_hit_s;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: SRAM-wait FSM with watchdog, priority gating, perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int PERF_LEN    = PERF_LEN_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  pipeline_ctrl_if.slave bus
);

  localparam logic [WATCHDOG_LEN-1:0] WD_LAST  = WATCHDOG_LEN'(MEM_TIMEOUT - 1);
  localparam logic [PERF_LEN-1:0]     CNT_MAX  = {PERF_LEN{1'b1}};
  localparam logic [PERF_LEN-1:0]     CNT_ONE  = {{(PERF_LEN-1){1'b0}}, 1'b1};

  logic [1:0]              state_r;
  logic [1:0]              state_nxt_s;
  logic [WATCHDOG_LEN-1:0] wd_r;
  logic [WATCHDOG_LEN-1:0] wd_nxt_s;
  logic [PERF_LEN-1:0]     stall_cnt_r;
  logic [PERF_LEN-1:0]     flush_cnt_r;
  logic                    mem_stall_s;
  logic                    hazard_s;
  logic                    if_freeze_s;
  logic                    if_flush_s;
  logic                    id_flush_s;
  logic                    hazard_stall_s;
  logic                    branch_flush_s;

  // Counters stick at all-ones instead of wrapping
  function automatic logic [PERF_LEN-1:0] sat_inc(input logic [PERF_LEN-1:0] value);
    if (value == CNT_MAX) begin
      return value;
    end else begin
      return value + CNT_ONE;
    end
  endfunction

  pipeline_ctrl_hazard_detect u_hazard_detect (
    .forward_en   (bus.forward_en),
    .id_src1      (bus.id_src1),
    .id_src2      (bus.id_src2),
    .id_use_src1  (bus.id_use_src1),
    .id_two_src   (bus.id_two_src),
    .exe_dest     (bus.exe_dest),
    .exe_wb_en    (bus.exe_wb_en),
    .exe_mem_read (bus.exe_mem_read),
    .mem_dest     (bus.mem_dest),
    .mem_wb_en    (bus.mem_wb_en),
    .hazard       (hazard_s)
  );

  // Memory-wait FSM: decide the stall and the next state/watchdog value
  always_comb begin
    state_nxt_s = state_r;
    wd_nxt_s    = wd_r;
    mem_stall_s = 1'b0;
    case (state_r)
      PCTRL_RUN: begin
        mem_stall_s = bus.mem_access_req & ~bus.mem_ready;
        if (mem_stall_s) begin
          state_nxt_s = PCTRL_MEM_WAIT;
          wd_nxt_s    = {WATCHDOG_LEN{1'b0}};
        end else begin
          state_nxt_s = PCTRL_RUN;
        end
      end
      PCTRL_MEM_WAIT: begin
        mem_stall_s = ~bus.mem_ready;
        if (bus.mem_ready) begin
          // A late completion still wins over a watchdog trip in the same cycle
          state_nxt_s = PCTRL_RUN;
        end else if (wd_r == WD_LAST) begin
          state_nxt_s = PCTRL_ERROR;
        end else begin
          wd_nxt_s = wd_r + {{(WATCHDOG_LEN-1){1'b0}}, 1'b1};
        end
      end
      PCTRL_ERROR: begin
        mem_stall_s = 1'b1;
        state_nxt_s = PCTRL_ERROR;
      end
      default: begin
        // An unreachable encoding is treated as a fault: freeze and latch the error
        mem_stall_s = 1'b1;
        state_nxt_s = PCTRL_ERROR;
      end
    endcase
  end

  // Priority gating: freeze, then branch flush, then hazard bubble
  always_comb begin
    if_freeze_s    = 1'b0;
    if_flush_s     = 1'b0;
    id_flush_s     = 1'b0;
    hazard_stall_s = 1'b0;
    branch_flush_s = 1'b0;
    if (mem_stall_s) begin
      // Inputs are re-presented next cycle, so branch/hazard actions simply wait
      if_freeze_s = 1'b1;
    end else if (bus.exe_branch_taken) begin
      // The ID instruction is squashed, so its hazard is irrelevant
      if_flush_s     = 1'b1;
      id_flush_s     = 1'b1;
      branch_flush_s = 1'b1;
    end else if (hazard_s) begin
      if_freeze_s    = 1'b1;
      id_flush_s     = 1'b1;
      hazard_stall_s = 1'b1;
    end else begin
      if_freeze_s = 1'b0;
    end
  end

  // FSM, watchdog and performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= PCTRL_RUN;
      wd_r        <= {WATCHDOG_LEN{1'b0}};
      stall_cnt_r <= {PERF_LEN{1'b0}};
      flush_cnt_r <= {PERF_LEN{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      wd_r    <= wd_nxt_s;
      if (mem_stall_s | hazard_stall_s) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (branch_flush_s) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
    end
  end

  assign bus.pipe_freeze     = mem_stall_s;
  assign bus.if_freeze       = if_freeze_s;
  assign bus.if_flush        = if_flush_s;
  assign bus.id_flush        = id_flush_s;
  assign bus.hazard          = hazard_s;
  assign bus.mem_timeout_err = (state_r == PCTRL_ERROR);
  assign bus.stall_count     = stall_cnt_r;
  assign bus.flush_count     = flush_cnt_r;

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage ARM pipeline. It sequences the IF, IF/ID, ID/EX, EX/MEM and MEM/WB stage registers from three sources: EX-stage branch resolution, ID-stage data hazards, and a variable-latency SRAM handshake in MEM. It also runs a memory-wait watchdog and two saturating performance counters.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before the watchdog trips (1..65535).
- PERF_LEN, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  reset; asynchronous, active-high.
- forward_en  in  1  forwarding unit enabled (runtime).
- id_src1  in  4  Rn of the instruction in ID.
- id_src2  in  4  Rm/Rd source of the instruction in ID.
- id_use_src1  in  1  ID instruction reads src1.
- id_two_src  in  1  ID instruction reads src2.
- exe_dest  in  4  destination register in EX.
- exe_wb_en  in  1  EX instruction writes back.
- exe_mem_read  in  1  EX instruction is a load.
- mem_dest  in  4  destination register in MEM.
- mem_wb_en  in  1  MEM instruction writes back.
- exe_branch_taken  in  1  branch resolved taken in EX.
- mem_access_req  in  1  MEM instruction is a load or store.
- mem_ready  in  1  SRAM controller completion pulse or level.
- pipe_freeze  out  1  hold every stage register and the PC.
- if_freeze  out  1  hold the PC and the IF/ID register.
- if_flush  out  1  clear the IF/ID register.
- id_flush  out  1  clear the ID/EX register (bubble).
- hazard  out  1  raw hazard detection, ungated.
- mem_timeout_err  out  1  sticky watchdog error.
- stall_count  out  PERF_LEN  saturating stall-cycle counter.
- flush_count  out  PERF_LEN  saturating branch-flush counter.

## Operation
FSM states are RUN, MEM_WAIT and ERROR.

- **RUN:**
  - mem_access_req=1 and mem_ready=0: go to MEM_WAIT and clear the watchdog.
  - Otherwise stay in RUN.
- **MEM_WAIT:**
  - mem_ready=1: go to RUN.
  - Otherwise the watchdog increments. When the watchdog equals MEM_TIMEOUT-1 and mem_ready=0, go to ERROR.
- **ERROR:** terminal until rst.
  - mem_timeout_err=1.
  - pipe_freeze=1.

mem_stall (combinational):
- RUN: mem_access_req & ~mem_ready.
- MEM_WAIT: ~mem_ready.
- ERROR: 1.

pipe_freeze = mem_stall.

Hazard detection (combinational):
- **forward_en=0:** hazard is set by any of:
  - id_use_src1 & exe_wb_en & (id_src1==exe_dest)
  - id_two_src & exe_wb_en & (id_src2==exe_dest)
  - the same two terms against mem_dest/mem_wb_en.
- **forward_en=1:** hazard = exe_mem_read & exe_wb_en & ((id_use_src1 & id_src1==exe_dest) | (id_two_src & id_src2==exe_dest)).

Output priority, highest first:
1. **pipe_freeze=1:** if_freeze=1, if_flush=0, id_flush=0. Branch and hazard actions are deferred, because the inputs are re-presented next cycle.
2. **exe_branch_taken=1:** if_flush=1, id_flush=1, if_freeze=0. The hazard is ignored because the ID instruction is squashed.
3. **hazard=1:** if_freeze=1, id_flush=1, if_flush=0.
4. **Otherwise:** all control outputs are 0.

Counters:
- stall_count increments in each cycle where pipe_freeze or the gated hazard stall is asserted.
- flush_count increments in each cycle where a branch flush is emitted (priority 2 taken).
- Both saturate at all-ones and never wrap.

## Timing
- All control outputs are combinational from the inputs and the registered state; there is zero-cycle latency to the stage registers. The registers act on the next posedge.
- Reset values:
  - State RUN, watchdog 0.
  - stall_count=0, flush_count=0, mem_timeout_err=0.
  - With inputs idle, all control outputs are 0.
- A mem_ready pulse in the same cycle as the first mem_access_req costs no stall and no state change.
- In MEM_WAIT, the cycle where mem_ready=1 has pipe_freeze=0. The pipeline advances at that edge and the state returns to RUN.
- mem_ready asserted in the cycle where the watchdog would trip wins: the FSM goes to RUN, not ERROR.
- A branch and a hazard in the same cycle count one flush and no stall.
- rst asserted mid-MEM_WAIT or in ERROR returns the FSM to RUN immediately and clears all counters and the error flag.

## Structure
- defines.v holds:
  - REGFILE_ADDRESS_LEN (4).
  - The FSM state encodings PCTRL_RUN, PCTRL_MEM_WAIT and PCTRL_ERROR (2 bits).
  - PERF_LEN default.
- One combinational sub-module, hazard_detect, holds the forward_en-dependent comparison logic. It has the ID/EX/MEM source/dest/enable inputs and a single hazard output.
- The FSM, watchdog, priority gating and counters live in pipeline_ctrl.

## Test plan
- **RAW hazard, no forwarding:** forward_en=0, id_src1=3, id_use_src1=1, exe_dest=3, exe_wb_en=1 -> hazard=1, if_freeze=1, id_flush=1, stall_count increments by 1.
- **Load-use with forwarding:**
  - forward_en=1, exe_mem_read=1, id_src2=5, id_two_src=1, exe_dest=5 -> stall.
  - Same setup with exe_mem_read=0 -> no stall.
- **Branch beats hazard:** exe_branch_taken=1 together with an active hazard -> if_flush=1, id_flush=1, if_freeze=0, flush_count+1, stall_count unchanged.
- **SRAM wait:** mem_access_req=1 with mem_ready low for 4 cycles, then high -> pipe_freeze=1 for exactly 4 cycles, a branch presented during the wait produces no flush, FSM returns to RUN, stall_count=4.
- **Watchdog:** MEM_TIMEOUT=8 and mem_ready held low -> ERROR entered after 8 wait cycles, mem_timeout_err=1, pipe_freeze stuck at 1. Async rst then clears everything without a clock edge.
- **Saturation:** PERF_LEN=4 with 20 consecutive stall cycles -> stall_count=15 and held.
